// File: rtl/saber_cmd_pkg.sv
// Shared types and helpers for the Saber command sequencer: instruction kinds,
// FSM states, error codes and command-word field slicing.
package saber_cmd_pkg;

  typedef enum logic [1:0] {
    KIND_WAIT = 2'b00,
    KIND_OP   = 2'b01,
    KIND_LEN  = 2'b10,
    KIND_HALT = 2'b11
  } instr_kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_ERR
  } seq_state_e;

  localparam int OP_CLEAR = 0;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_PC_OVF  = 2'd2;

  // Command layout is {dest, src2, src1, opcode} for OP and {out_len, in_len} for LEN.
  function automatic logic [63:0] field_of(input logic [63:0] cmd, input int lsb, input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (cmd >> lsb) & mask;
  endfunction

  function automatic logic [63:0] opcode_of(input logic [63:0] cmd, input int op_w);
    return field_of(cmd, 0, op_w);
  endfunction

  function automatic logic [63:0] src1_of(input logic [63:0] cmd, input int addr_w, input int op_w);
    return field_of(cmd, op_w, addr_w);
  endfunction

  function automatic logic [63:0] src2_of(input logic [63:0] cmd, input int addr_w, input int op_w);
    return field_of(cmd, op_w + addr_w, addr_w);
  endfunction

  function automatic logic [63:0] dest_of(input logic [63:0] cmd, input int addr_w, input int op_w);
    return field_of(cmd, op_w + 2 * addr_w, addr_w);
  endfunction

  function automatic logic [63:0] in_len_of(input logic [63:0] cmd, input int len_w);
    return field_of(cmd, 0, len_w);
  endfunction

  function automatic logic [63:0] out_len_of(input logic [63:0] cmd, input int len_w);
    return field_of(cmd, len_w, len_w);
  endfunction

endpackage

// File: rtl/saber_cmd_rom.sv
// Program store for the command sequencer: one write port, one synchronous
// read port with a single cycle of latency. Contents survive reset.
module saber_cmd_rom #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/saber_cmd_sequencer.sv
// Replays stored {we1, we0, cmd} words into the Saber core command port,
// stalling on core completion between operations.
module saber_cmd_sequencer
  import saber_cmd_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int OP_W    = 5,
  parameter int LEN_W   = 16,
  parameter int CMD_W   = 3 * ADDR_W + OP_W,
  parameter int DEPTH   = 128,
  parameter int PC_W    = $clog2(DEPTH),
  parameter int TIMEOUT = 2**20 - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [CMD_W+1:0]  prog_data,
  input  logic              start,
  input  logic [PC_W-1:0]   start_pc,
  input  logic              abort,
  input  logic              core_done,
  output logic [CMD_W-1:0]  command_in,
  output logic              command_we0,
  output logic              command_we1,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [PC_W-1:0]   pc
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - 1);

  if (CMD_W < 2 * LEN_W + 1) begin : g_bad_cmd_w
    $error("CMD_W too narrow to hold both length fields");
  end

  seq_state_e        state;
  logic [CMD_W+1:0]  instr;
  logic [CMD_W-1:0]  cmd;
  instr_kind_e       kind;
  logic              op_live;
  logic              pc_last;
  logic              done_seen;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              timeout_hit;

  saber_cmd_rom #(
    .WIDTH (CMD_W + 2),
    .DEPTH (DEPTH),
    .AW    (PC_W)
  ) u_rom (
    .clk   (clk),
    .we    (prog_we && !busy),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (instr)
  );

  assign cmd         = instr[CMD_W-1:0];
  assign kind        = instr_kind_e'(instr[CMD_W+1 -: 2]);
  assign op_live     = (opcode_of(64'(cmd), OP_W) != 64'(OP_CLEAR));
  assign pc_last     = (pc == LAST_PC);
  assign cnt_next    = wait_cnt + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_next == CNT_W'(TIMEOUT));

  // core_done can arrive early, so it is latched in done_seen; any clear is
  // skipped when a new core_done lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      command_in  <= '0;
      command_we0 <= 1'b0;
      command_we1 <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      pc          <= '0;
      done_seen   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      command_we0 <= 1'b0;
      command_we1 <= 1'b0;
      done        <= 1'b0;
      if (core_done) done_seen <= 1'b1;

      if (abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        done_seen <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              pc       <= start_pc;
              error    <= 1'b0;
              err_code <= ERR_NONE;
              busy     <= 1'b1;
              state    <= S_FETCH;
            end
          end
          S_FETCH: begin
            wait_cnt <= '0;
            state    <= S_EXEC;
          end
          S_EXEC: begin
            case (kind)
              KIND_LEN, KIND_OP: begin
                command_in  <= cmd;
                command_we1 <= (kind == KIND_LEN);
                command_we0 <= (kind == KIND_OP);
                if (kind == KIND_OP && op_live && !core_done) done_seen <= 1'b0;
                if (pc_last) begin
                  error    <= 1'b1;
                  err_code <= ERR_PC_OVF;
                  busy     <= 1'b0;
                  state    <= S_ERR;
                end else begin
                  pc    <= pc + 1'b1;
                  state <= S_FETCH;
                end
              end
              KIND_WAIT: state <= S_WAIT;
              default: begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end
            endcase
          end
          S_WAIT: begin
            if (done_seen) begin
              if (!core_done) done_seen <= 1'b0;
              if (pc_last) begin
                error    <= 1'b1;
                err_code <= ERR_PC_OVF;
                busy     <= 1'b0;
                state    <= S_ERR;
              end else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end else if (timeout_hit) begin
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
              busy     <= 1'b0;
              state    <= S_ERR;
            end else begin
              wait_cnt <= cnt_next;
            end
          end
          S_ERR: begin
            busy <= 1'b0;
            if (start) begin
              error    <= 1'b0;
              err_code <= ERR_NONE;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_saber_cmd_sequencer.sv
// Directed bench for saber_cmd_sequencer (DEPTH=8, TIMEOUT=16); every issued
// strobe is logged as {we1, we0, cmd} and compared with hand-built words.
module tb_saber_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [2:0]  prog_addr = '0;
  logic [36:0] prog_data = '0;
  logic        start = 1'b0;
  logic [2:0]  start_pc = '0;
  logic        abort = 1'b0;
  logic        core_done = 1'b0;
  logic [34:0] command_in;
  logic        command_we0;
  logic        command_we1;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [2:0]  pc;

  int errors = 0;
  int checks = 0;
  logic [36:0] log_q [$];

  localparam logic [36:0] WAIT_W = 37'h0;
  localparam logic [36:0] HALT_W = {2'b11, 35'h0};
  localparam logic [36:0] LEN_W0 = 37'h1000200020;

  saber_cmd_sequencer #(
    .ADDR_W (10), .OP_W (5), .LEN_W (16), .DEPTH (8), .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .start_pc    (start_pc),
    .abort       (abort),
    .core_done   (core_done),
    .command_in  (command_in),
    .command_we0 (command_we0),
    .command_we1 (command_we1),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (command_we0 === 1'b1 || command_we1 === 1'b1)
      log_q.push_back({command_we1, command_we0, command_in});
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [36:0] op_word(input int dest, input int src2, input int src1, input int opc);
    return {2'b01, 10'(dest), 10'(src2), 10'(src1), 5'(opc)};
  endfunction

  task automatic write_word(input int a, input logic [36:0] d);
    prog_addr = 3'(a);
    prog_data = d;
    prog_we   = 1'b1;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start(input int spc);
    start_pc = 3'(spc);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({command_in, command_we0, command_we1, busy, done, error, err_code, pc} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b error=%b err_code=%0d pc=%0d we0=%b we1=%b cmd=%h, need all 0",
               busy, done, error, err_code, pc, command_we0, command_we1, command_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_program();
    int cyc;
    bit got;
    logic [36:0] exp [4];
    write_word(0, LEN_W0);
    write_word(1, op_word(0, 0, 0, 0));
    write_word(2, op_word(896, 0, 0, 3));
    write_word(3, WAIT_W);
    write_word(4, op_word(0, 0, 0, 0));
    write_word(5, HALT_W);
    exp[0] = LEN_W0;
    exp[1] = op_word(0, 0, 0, 0);
    exp[2] = op_word(896, 0, 0, 3);
    exp[3] = op_word(0, 0, 0, 0);
    log_q.delete();
    pulse_start(0);
    cyc = 1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prog_busy_rise: got %b, need 1", busy);
    end
    got = 1'b0;
    while (!got && cyc < 100) begin
      if (cyc == 20) begin
        checks++;
        if (log_q.size() != 3) begin
          errors++;
          $display("[TB] FAIL prog_stall: got %0d strobes before core_done, need 3", log_q.size());
        end
      end
      core_done = (cyc == 20);
      @(negedge clk);
      cyc++;
      if (done === 1'b1) got = 1'b1;
    end
    core_done = 1'b0;
    checks++;
    if (!got || cyc != 26) begin
      errors++;
      $display("[TB] FAIL prog_done_time: got done=%b at cycle %0d, need done at cycle 26", got, cyc);
    end
    checks++;
    if (log_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL prog_strobe_count: got %0d, need 4", log_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) begin
        checks++;
        if (log_q[i] !== exp[i]) begin
          errors++;
          $display("[TB] FAIL prog_strobe_%0d: got %h, need %h", i, log_q[i], exp[i]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pc !== 3'd5 || error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prog_end_state: got busy=%b done=%b pc=%0d error=%b, need busy=0 done=0 pc=5 error=0",
               busy, done, pc, error);
    end
  endtask

  task automatic test_early_done();
    int n;
    logic [36:0] w3;
    w3 = op_word(896, 0, 0, 3);
    log_q.delete();
    pulse_start(0);
    n = 0;
    while (!(command_we0 === 1'b1 && command_in === w3[34:0]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("[TB] FAIL early_op3_time: got op3 strobe after %0d cycles, need 6", n);
    end
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("[TB] FAIL early_wait_exit: got done %0d cycles after core_done, need 5", n);
    end
    checks++;
    if (log_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL early_strobe_count: got %0d, need 4", log_q.size());
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pc !== 3'd5) begin
      errors++;
      $display("[TB] FAIL early_end: got busy=%b pc=%0d, need busy=0 pc=5", busy, pc);
    end
  endtask

  task automatic test_timeout();
    int n;
    write_word(6, WAIT_W);
    log_q.delete();
    pulse_start(6);
    n = 1;
    while (error !== 1'b1 && n < 60) begin
      if (n == 10) begin
        checks++;
        if (busy !== 1'b1 || error !== 1'b0) begin
          errors++;
          $display("[TB] FAIL timeout_early: got busy=%b error=%b mid-wait, need busy=1 error=0", busy, error);
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 19 || n > 20) begin
      errors++;
      $display("[TB] FAIL timeout_time: got error at cycle %0d, need cycle 19..20", n);
    end
    checks++;
    if (err_code !== 2'd1 || busy !== 1'b0 || command_we0 !== 1'b0 || command_we1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_state: got err_code=%0d busy=%b we0=%b we1=%b, need 1/0/0/0",
               err_code, busy, command_we0, command_we1);
    end
    checks++;
    if (log_q.size() != 0 || pc !== 3'd6) begin
      errors++;
      $display("[TB] FAIL timeout_no_strobe: got %0d strobes pc=%0d, need 0 strobes pc=6", log_q.size(), pc);
    end
    pulse_start(0);
    checks++;
    if (error !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got error=%b err_code=%0d busy=%b, need 0/0/0", error, err_code, busy);
    end
  endtask

  task automatic test_pc_overflow();
    int n;
    logic [36:0] w;
    for (int i = 0; i < 8; i++) write_word(i, op_word(i + 1, 0, 0, i + 1));
    log_q.delete();
    pulse_start(0);
    n = 0;
    while (error !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0 || pc !== 3'd7) begin
      errors++;
      $display("[TB] FAIL ovf_state: got error=%b err_code=%0d busy=%b pc=%0d, need 1/2/0/7", error, err_code, busy, pc);
    end
    checks++;
    if (log_q.size() != 8) begin
      errors++;
      $display("[TB] FAIL ovf_strobe_count: got %0d, need 8", log_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < log_q.size()) begin
        w = op_word(i + 1, 0, 0, i + 1);
        checks++;
        if (log_q[i] !== w) begin
          errors++;
          $display("[TB] FAIL ovf_strobe_%0d: got %h, need %h", i, log_q[i], w);
        end
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (log_q.size() != 8) begin
      errors++;
      $display("[TB] FAIL ovf_no_ninth: got %0d strobes, need 8", log_q.size());
    end
    pulse_start(0);
  endtask

  task automatic test_abort();
    int n;
    logic [36:0] wa, wc;
    wa = op_word(1, 2, 3, 4);
    wc = op_word(9, 10, 11, 12);
    write_word(0, wa);
    write_word(1, op_word(5, 6, 7, 8));
    write_word(2, wc);
    write_word(3, HALT_W);
    log_q.delete();
    pulse_start(0);
    n = 0;
    while (!(command_we0 === 1'b1 && command_in === wa[34:0]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (command_we0 !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_state: got we0=%b busy=%b done=%b error=%b, need all 0", command_we0, busy, done, error);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (log_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL abort_no_strobe: got %0d strobes, need 1", log_q.size());
    end
    start_pc = 3'd0;
    start    = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_beats_start: got busy=%b, need 0", busy);
    end
    pulse_start(2);
    n = 1;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 5 || pc !== 3'd3) begin
      errors++;
      $display("[TB] FAIL abort_restart: got done at cycle %0d pc=%0d, need cycle 5 pc=3", n, pc);
    end
    checks++;
    if (log_q.size() != 2 || log_q[log_q.size()-1] !== wc) begin
      errors++;
      $display("[TB] FAIL abort_restart_word: got %0d strobes last=%h, need 2 strobes last=%h",
               log_q.size(), log_q[log_q.size()-1], wc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    logic [36:0] wd;
    wd = op_word(20, 21, 22, 23);
    write_word(0, wd);
    write_word(1, WAIT_W);
    write_word(2, HALT_W);
    log_q.delete();
    pulse_start(0);
    repeat (7) @(negedge clk);
    checks++;
    if (command_in !== wd[34:0] || command_we0 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_cmd: got cmd=%h we0=%b busy=%b, need cmd=%h we0=0 busy=1",
               command_in, command_we0, busy, wd[34:0]);
    end
    write_word(0, op_word(1, 1, 1, 1));
    rst_n = 1'b0;
    #1;
    checks++;
    if ({command_in, command_we0, command_we1, busy, done, error, err_code, pc} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got busy=%b pc=%0d cmd=%h error=%b, need all 0", busy, pc, command_in, error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    log_q.delete();
    pulse_start(0);
    n = 0;
    while (command_we0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (command_in !== wd[34:0]) begin
      errors++;
      $display("[TB] FAIL busy_write_dropped: got cmd=%h, need %h", command_in, wd[34:0]);
    end
    repeat (3) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || pc !== 3'd2) begin
      errors++;
      $display("[TB] FAIL reset_rerun: got done=%b pc=%0d, need done=1 pc=2", done, pc);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_early_done();
    test_timeout();
    test_pc_overflow();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/saber_cmd_sequencer.md
Name: saber_cmd_sequencer

Overview:
- Programmable sequencer that replays stored 37-bit instruction words {we1, we0, cmd} into the Saber compute core's command port.
- Waits on core completion between operations, so KEM keygen/enc/dec programs run on-chip without a host driving every cycle.
- Generalised over address/opcode/length widths and program depth; adds HALT, done-wait with timeout, abort, and a selectable start PC.
- Sits between the host/program loader and the compute core.

Parameters:
- ADDR_W, 10, width of each RAM address field (dest, src2, src1).
- OP_W, 5, opcode width.
- LEN_W, 16, SHAKE output/input length field width.
- CMD_W, 3*ADDR_W+OP_W (35), command width; must be >= 2*LEN_W+1.
- DEPTH, 128, program memory words.
- PC_W, $clog2(DEPTH), program counter width.
- TIMEOUT, 2**20-1, maximum WAIT cycles before error; 0 disables the timeout.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- prog_we, in, 1, program memory write strobe.
- prog_addr, in, PC_W, program write address.
- prog_data, in, CMD_W+2, instruction word.
- start, in, 1, start pulse.
- start_pc, in, PC_W, first instruction address.
- abort, in, 1, synchronous abort.
- core_done, in, 1, one-cycle completion pulse from the core.
- command_in, out, CMD_W, command to the core.
- command_we0, out, 1, operation strobe.
- command_we1, out, 1, length-register strobe.
- busy, out, 1, program running.
- done, out, 1, one-cycle pulse on HALT.
- error, out, 1, sticky error flag; cleared by start.
- err_code, out, 2, error cause: 0 none, 1 timeout, 2 PC overflow.
- pc, out, PC_W, current PC.

Behaviour:
- Reset: all outputs 0, state IDLE, done_seen 0, timeout counter 0.
- Instruction decode, by {we1, we0}:
  - 10 = LEN: pulse command_we1 with cmd.
  - 01 = OP: pulse command_we0 with cmd; opcode 0 is the core clear.
  - 00 = WAIT.
  - 11 = HALT.
- Program memory: synchronous read, 1-cycle latency.
  - prog_we is accepted only while busy=0; writes while busy are dropped silently.
- FSM states: IDLE, FETCH, EXEC, WAIT, ERR.
  - IDLE: on start, pc<=start_pc, error<=0, err_code<=0, busy<=1, go to FETCH. start while busy is ignored.
  - FETCH: present pc to memory; go to EXEC.
  - EXEC, LEN/OP: next cycle command_in<=cmd and the strobe goes high for exactly 1 cycle; pc<=pc+1; go to FETCH. A strobe is therefore issued at most every 2 cycles.
  - EXEC, WAIT: go to WAIT; pc is unchanged until the wait completes.
  - EXEC, HALT: busy<=0, done pulses 1 cycle, go to IDLE; pc stays at the HALT address.
  - WAIT: when done_seen=1, clear done_seen, pc<=pc+1, go to FETCH. Otherwise increment the counter. If counter==TIMEOUT (TIMEOUT≠0): error<=1, err_code<=1, go to ERR.
  - ERR: busy<=0, strobes 0; go to IDLE on the next start.
- Between strobes, command_in holds the last issued value; strobes are never high outside the issue cycle.
- done_seen: sticky.
  - Set by core_done in any state.
  - Cleared when an OP with nonzero opcode is strobed.
  - If set and clear coincide, set wins.
  - This lets a fast core finish before the WAIT is reached.
- PC overflow: incrementing from DEPTH-1 sets error<=1, err_code<=2, goes to ERR; no wrap.
- Abort (any state): next cycle IDLE, busy 0, strobes 0, done 0, done_seen 0; error is unchanged; abort wins over start.
- Async reset mid-program returns immediately to reset values; program memory contents are not cleared.

Decomposition:
- saber_cmd_pkg:
  - instruction kind localparams (LEN/OP/WAIT/HALT);
  - OP_CLEAR=0;
  - field-slice helper functions (dest/src2/src1/opcode, out_len/in_len);
  - err_code constants.
- Sub-module saber_cmd_rom: single-port-write / sync-read memory, DEPTH×(CMD_W+2).
- FSM and counters live in the top module.

Test Plan:
1. Load [0]=37'h1000200020 (LEN 32/32), [1]=OP{0,0,0,0}, [2]=OP{896,0,0,3}, [3]=WAIT, [4]=OP 0, [5]=HALT; start_pc=0; core_done at cycle 20 -> exact sequence: we1 with cmd 0x200020; we0 0x0; we0 {896,0,0,3}; stall until core_done; we0 0x0; done pulse; busy drops; pc=5.
2. Same program with core_done fired 1 cycle after the opcode-3 strobe (before WAIT is reached) -> WAIT exits in 1 cycle, no hang.
3. TIMEOUT=16, WAIT with no core_done -> error=1, err_code=1 after 16 wait cycles; strobes stay 0; busy=0.
4. DEPTH=8, program of 8 OP words with no HALT -> 8 we0 strobes, then err_code=2, no ninth strobe.
5. Abort asserted in the cycle a strobe would issue -> no strobe; IDLE next cycle; restart with start_pc=2 begins at word 2.
6. rst_n low during WAIT -> all outputs 0 at once; prog_we during busy is dropped (read back the old word after HALT).
